// File: rtl/key_debounce_arbiter.sv
// Input stage for the colour-memory game: synchronises and debounces four colour keys
// and start, then emits one-hot key pulses with a release lockout. Optional: KEY_REPEAT_EN.
module key_debounce_arbiter #(
    parameter int DEB_CYCLES    = 4,
    parameter int DEB_W         = 3
`ifdef KEY_REPEAT_EN
    ,
    parameter int REPEAT_CYCLES = 32
`endif
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] raw_k,
    input  logic       raw_start,
    output logic [3:0] k,
    output logic       start,
    output logic [1:0] key_code,
    output logic       key_busy
);
    localparam int               NIN      = 5;
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
    localparam logic [0:0]       ST_IDLE  = 1'b0;
    localparam logic [0:0]       ST_HELD  = 1'b1;

    logic [NIN-1:0]            raw_all;
    logic [NIN-1:0]            meta_q, sync_q;
    logic [NIN-1:0]            deb_q, deb_d, deb_dly_q;
    logic [NIN-1:0]            rise;
    logic [NIN-1:0][DEB_W-1:0] cnt_q, cnt_d;
    logic [0:0]                state_q, state_d;
    logic [3:0]                k_q, k_d;
    logic                      start_q;
    logic [1:0]                code_q, code_d;

`ifdef KEY_REPEAT_EN
    localparam int               REP_W    = $clog2(REPEAT_CYCLES);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);
    logic [REP_W-1:0]            rep_q, rep_d;
`endif

    // Bit 4 carries start so all five inputs share one sync/debounce path.
    assign raw_all = {raw_start, raw_k};
    assign rise    = deb_q & ~deb_dly_q;

    always_comb begin
        cnt_d = cnt_q;
        deb_d = deb_q;
        for (int i = 0; i < NIN; i++) begin
            if (sync_q[i] == deb_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == DEB_LAST) begin
                deb_d[i] = sync_q[i];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = '0;
        code_d  = code_q;
`ifdef KEY_REPEAT_EN
        rep_d   = '0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (|rise[3:0]) begin
                    // Descending scan so the lowest set index is written last and wins.
                    for (int i = 3; i >= 0; i--) begin
                        if (rise[i]) code_d = 2'(i);
                    end
                    k_d     = 4'b0001 << code_d;
                    state_d = ST_HELD;
                end
            end
            ST_HELD: begin
                if (deb_q[3:0] == 4'b0000) state_d = ST_IDLE;
`ifdef KEY_REPEAT_EN
                if (deb_q[code_q]) begin
                    if (rep_q == REP_LAST) begin
                        k_d   = 4'b0001 << code_q;
                        rep_d = '0;
                    end else begin
                        rep_d = rep_q + 1'b1;
                    end
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            meta_q    <= '0;
            sync_q    <= '0;
            deb_q     <= '0;
            deb_dly_q <= '0;
            cnt_q     <= '0;
            state_q   <= ST_IDLE;
            k_q       <= '0;
            start_q   <= 1'b0;
            code_q    <= '0;
        end else begin
            meta_q    <= raw_all;
            sync_q    <= meta_q;
            deb_q     <= deb_d;
            deb_dly_q <= deb_q;
            cnt_q     <= cnt_d;
            state_q   <= state_d;
            k_q       <= k_d;
            start_q   <= rise[4];
            code_q    <= code_d;
        end
    end

`ifdef KEY_REPEAT_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) rep_q <= '0;
        else       rep_q <= rep_d;
    end
`endif

    assign k        = k_q;
    assign start    = start_q;
    assign key_code = code_q;
    assign key_busy = (state_q == ST_HELD);

endmodule

// File: tb/tb_key_debounce_arbiter.sv
// Bench for key_debounce_arbiter: vector table, directed corner sequences and random
// stimulus compared each cycle against a sample-window reference model.
module tb_key_debounce_arbiter;
    localparam int DEB = 4;
    localparam int REP = 32;

    logic       clock;
    logic       reset;
    logic [3:0] raw_k;
    logic       raw_start;
    logic [3:0] k;
    logic       start;
    logic [1:0] key_code;
    logic       key_busy;

    int checks = 0;
    int errors = 0;

    key_debounce_arbiter dut (
        .clock    (clock),
        .reset    (reset),
        .raw_k    (raw_k),
        .raw_start(raw_start),
        .k        (k),
        .start    (start),
        .key_code (key_code),
        .key_busy (key_busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Reference model: deb toggles once the last DEB synced samples all disagree with it.
    typedef struct {
        logic [4:0] hist [8];
        logic [4:0] deb;
        logic [4:0] debd;
        logic       lock;
        logic [1:0] code;
        int         held;
        logic [3:0] k;
        logic       start;
    } mdl_t;

    mdl_t m;

    function automatic mdl_t mreset();
        mdl_t z;
        for (int j = 0; j < 8; j++) z.hist[j] = '0;
        z.deb = '0; z.debd = '0; z.lock = 1'b0; z.code = '0;
        z.held = 0; z.k = '0; z.start = 1'b0;
        return z;
    endfunction

    function automatic mdl_t step(input mdl_t s, input logic [4:0] raw);
        mdl_t       n;
        logic [4:0] rise;
        logic       flip;
        n = s;
        for (int j = 7; j > 0; j--) n.hist[j] = s.hist[j-1];
        n.hist[0] = raw;
        rise = s.deb & ~s.debd;
        for (int b = 0; b < 5; b++) begin
            flip = 1'b1;
            for (int j = 2; j <= DEB + 1; j++) if (n.hist[j][b] == s.deb[b]) flip = 1'b0;
            if (flip) n.deb[b] = ~s.deb[b];
        end
        n.debd  = s.deb;
        n.k     = '0;
        n.start = rise[4];
        if (!s.lock) begin
            if (rise[3:0] != 4'b0000) begin
                for (int j = 3; j >= 0; j--) if (rise[j]) n.code = 2'(j);
                n.k    = 4'b0001 << n.code;
                n.lock = 1'b1;
                n.held = 0;
            end
        end else begin
            if (s.deb[3:0] == 4'b0000) n.lock = 1'b0;
`ifdef KEY_REPEAT_EN
            if (s.deb[s.code]) begin
                n.held = s.held + 1;
                if (n.held % REP == 0) n.k = 4'b0001 << s.code;
            end else begin
                n.held = 0;
            end
`endif
        end
        return n;
    endfunction

    always @(posedge clock or posedge reset) begin
        if (reset) m <= mreset();
        else       m <= step(m, {raw_start, raw_k});
    end

    logic [3:0] prev_k = '0;
    always @(negedge clock) begin
        chk("mdl_k", 32'(k), 32'(m.k));
        chk("mdl_start", 32'(start), 32'(m.start));
        chk("mdl_code", 32'(key_code), 32'(m.code));
        chk("mdl_busy", 32'(key_busy), 32'(m.lock));
        chk("k_onehot", 32'($onehot0(k) && !((k != 0) && (prev_k != 0))), 32'd1);
        prev_k <= k;
    end

    typedef struct {
        logic       rst;
        logic [3:0] rk;
        logic       rs;
        logic [3:0] ek;
        logic       es;
        logic [1:0] ec;
        logic       eb;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input int n, input logic rst, input logic [3:0] rk, input logic rs,
                       input logic [3:0] ek, input logic es, input logic [1:0] ec, input logic eb);
        vec_t v;
        v.rst = rst; v.rk = rk; v.rs = rs; v.ek = ek; v.es = es; v.ec = ec; v.eb = eb;
        repeat (n) tbl.push_back(v);
    endtask

    task automatic wait_k(input int maxc, output int cyc, output logic [3:0] kv);
        bool_loop: begin
            cyc = -1;
            kv  = '0;
            for (int c = 1; c <= maxc; c++) begin
                @(negedge clock);
                if (k != 4'b0000) begin
                    cyc = c;
                    kv  = k;
                    disable bool_loop;
                end
            end
        end
    endtask

    task automatic wait_idle(input string nm, input int maxc);
        int c;
        c = 0;
        while (key_busy !== 1'b0 && c < maxc) begin
            @(negedge clock);
            c++;
        end
        chk(nm, 32'(key_busy), 32'd0);
        repeat (4) @(negedge clock);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int         cyc;
        int         nk;
        int         nst;
        int         pq[$];
        logic [3:0] kv;

        reset = 1'b1; raw_k = '0; raw_start = 1'b0;

        // Vector index equals the posedge number after reset release.
        add(1, 1, 4'b0100, 0, 4'b0000, 0, 2'd0, 0);
        add(6, 0, 4'b0100, 0, 4'b0000, 0, 2'd0, 0);
        add(1, 0, 4'b0100, 0, 4'b0100, 0, 2'd2, 1);
        add(1, 0, 4'b0100, 0, 4'b0000, 0, 2'd2, 1);
        add(6, 0, 4'b0000, 0, 4'b0000, 0, 2'd2, 1);
        add(4, 0, 4'b0000, 0, 4'b0000, 0, 2'd2, 0);
        add(3, 0, 4'b0010, 1, 4'b0000, 0, 2'd2, 0);
        add(9, 0, 4'b0000, 0, 4'b0000, 0, 2'd2, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            reset = tbl[i].rst; raw_k = tbl[i].rk; raw_start = tbl[i].rs;
            @(negedge clock);
            chk($sformatf("tbl[%0d]", i), 32'({k, start, key_code, key_busy}),
                32'({tbl[i].ek, tbl[i].es, tbl[i].ec, tbl[i].eb}));
        end

        // Two keys rising together: lowest wins, lockout held by the remaining key.
        raw_k = 4'b1010;
        wait_k(12, cyc, kv);
        chk("t3_lat", 32'(cyc), 32'd7);
        chk("t3_k", 32'(kv), 32'b0010);
        chk("t3_code", 32'(key_code), 32'd1);
        raw_k = 4'b1000;
        nk = 0;
        repeat (20) begin @(negedge clock); if (k != 0) nk++; end
        chk("t3_nopulse", 32'(nk), 32'd0);
        chk("t3_busy", 32'(key_busy), 32'd1);
        raw_k = 4'b0000;
        wait_idle("t3_idle", 15);

        // Start while a key is held.
        raw_k = 4'b0001;
        wait_k(12, cyc, kv);
        chk("t4_press", 32'(kv), 32'b0001);
        raw_start = 1'b1;
        nk = 0; nst = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clock);
            if (start) nst++;
            if (k != 0) nk++;
            if (c == 10) raw_start = 1'b0;
        end
        chk("t4_start_cnt", 32'(nst), 32'd1);
        chk("t4_k_quiet", 32'(nk), 32'd0);
        chk("t4_busy", 32'(key_busy), 32'd1);
        raw_k = 4'b0000;
        wait_idle("t4_idle", 15);

        // Reset mid-hold, key still held afterwards.
        raw_k = 4'b0100;
        wait_k(12, cyc, kv);
        chk("t5_first", 32'(kv), 32'b0100);
        repeat (3) @(negedge clock);
        #2 reset = 1'b1;
        #1 chk("t5_rst_now", 32'({k, start, key_code, key_busy}), 32'd0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        wait_k(12, cyc, kv);
        chk("t5_lat", 32'(cyc), 32'd7);
        chk("t5_k", 32'(kv), 32'b0100);
        nk = 0;
        repeat (10) begin @(negedge clock); if (k != 0) nk++; end
        chk("t5_single", 32'(nk), 32'd0);
        raw_k = 4'b0000;
        wait_idle("t5_idle", 15);

        // Long hold: repeat pulses only when built with KEY_REPEAT_EN.
        raw_k = 4'b0001;
        for (int c = 1; c <= 96; c++) begin
            @(negedge clock);
            if (k != 0) pq.push_back(c);
        end
        raw_k = 4'b0000;
        nk = 0;
        repeat (20) begin @(negedge clock); if (k != 0) nk++; end
`ifdef KEY_REPEAT_EN
        chk("t6_count", 32'(pq.size()), 32'd3);
        chk("t6_last", 32'(pq.size() > 0 ? pq[pq.size()-1] : -1), 32'd71);
`else
        chk("t6_count", 32'(pq.size()), 32'd1);
        chk("t6_last", 32'(pq.size() > 0 ? pq[pq.size()-1] : -1), 32'd7);
`endif
        chk("t6_first", 32'(pq.size() > 0 ? pq[0] : -1), 32'd7);
        chk("t6_released", 32'(nk), 32'd0);
        wait_idle("t6_idle", 15);

        // Random stimulus; the per-cycle model comparison does the checking.
        for (int seg = 0; seg < 250; seg++) begin
            case ($urandom_range(0, 4))
                0, 1:    raw_k = 4'b0000;
                2, 3:    raw_k = 4'b0001 << $urandom_range(0, 3);
                default: raw_k = 4'($urandom_range(0, 15));
            endcase
            raw_start = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 49) == 0) begin
                #3 reset = 1'b1;
                @(negedge clock);
                reset = 1'b0;
            end
            repeat ($urandom_range(1, 12)) @(negedge clock);
        end

        raw_k = '0; raw_start = 1'b0;
        repeat (10) @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
